fox86_memctl: RTL and testbench

//   Memory controller between the fox86 core byte bus and an external async
//   16-bit SRAM (1 MB, 512K words). Latches each CPU access, runs timed SRAM

---
 rtl/fox86_memctl.sv | 113 +++++++++++
 tb/tb_fox86_memctl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fox86_memctl.sv
// Memory controller between the fox86 byte bus and an asynchronous 16-bit SRAM.
// Each access runs IDLE -> SETUP -> STROBE x WAIT -> DONE, and cpu_ce pulses once at the end.
module fox86_memctl #(
  parameter int          WAIT     = 2,
  parameter logic [19:0] ROM_BASE = 20'hF0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] cpu_address,
  input  logic [7:0]  cpu_out,
  input  logic        cpu_we,
  output logic [7:0]  cpu_in,
  output logic        cpu_ce,
  output logic [18:0] sram_addr,
  output logic [15:0] sram_dq_o,
  input  logic [15:0] sram_dq_i,
  output logic        sram_dq_oe,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  localparam int STROBES = (WAIT < 1) ? 1 : WAIT;
  localparam int CW = (STROBES > 1) ? $clog2(STROBES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STROBES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  state_t        state;
  logic [19:0]   addr_q;
  logic [7:0]    data_q;
  logic          we_q;
  logic          wp_q;
  logic [CW-1:0] count;

  // Every output is registered and reflects the action taken in the state just left.
  // A protected write runs the full sequence with its lanes and write strobe held off,
  // so the core sees the same timing as for any other access.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      wp_q       <= 1'b0;
      count      <= '0;
      cpu_in     <= 8'h00;
      cpu_ce     <= 1'b0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          addr_q     <= cpu_address;
          data_q     <= cpu_out;
          we_q       <= cpu_we;
          wp_q       <= cpu_we && (cpu_address >= ROM_BASE);
          cpu_ce     <= 1'b0;
          sram_dq_oe <= 1'b0;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          sram_ub_n  <= 1'b1;
          sram_lb_n  <= 1'b1;
          state      <= SETUP;
        end
        SETUP: begin
          sram_addr <= addr_q[19:1];
          count     <= LAST;
          if (we_q) begin
            sram_dq_o  <= {data_q, data_q};
            sram_dq_oe <= 1'b1;
            sram_ub_n  <= !(addr_q[0] && !wp_q);
            sram_lb_n  <= !(!addr_q[0] && !wp_q);
          end else begin
            sram_oe_n <= 1'b0;
            sram_ub_n <= !addr_q[0];
            sram_lb_n <= addr_q[0];
          end
          state <= STROBE;
        end
        STROBE: begin
          sram_we_n <= !(we_q && !wp_q);
          if (count == '0) begin
            if (!we_q) begin
              cpu_in <= addr_q[0] ? sram_dq_i[15:8] : sram_dq_i[7:0];
            end
            state <= DONE;
          end else begin
            count <= count - 1'b1;
          end
        end
        DONE: begin
          // Strobes are released here so we_n rises a full clock before the address can move.
          sram_we_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_ub_n  <= 1'b1;
          sram_lb_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          cpu_ce     <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fox86_memctl.sv
// Directed bench for fox86_memctl: a sparse SRAM model behind the WAIT=2 instance,
// plus WAIT=1 and WAIT=4 instances that are used to check access periods.
module tb_fox86_memctl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] cpu_address = '0;
  logic [7:0]  cpu_out = '0;
  logic        cpu_we = 1'b0;

  logic [7:0]  cpu_in;
  logic        cpu_ce;
  logic [18:0] sram_addr;
  logic [15:0] sram_dq_o;
  logic [15:0] sram_dq_i = '0;
  logic        sram_dq_oe, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  logic [7:0]  w1_cpu_in, w4_cpu_in;
  logic        w1_ce, w4_ce;
  logic [18:0] w1_addr, w4_addr;
  logic [15:0] w1_dq_o, w4_dq_o, w1_dq_i, w4_dq_i;
  logic        w1_dq_oe, w1_oe_n, w1_we_n, w1_ub_n, w1_lb_n;
  logic        w4_dq_oe, w4_oe_n, w4_we_n, w4_ub_n, w4_lb_n;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  fox86_memctl #(.WAIT(2)) dut (
    .clock(clock), .reset(reset), .cpu_address(cpu_address), .cpu_out(cpu_out),
    .cpu_we(cpu_we), .cpu_in(cpu_in), .cpu_ce(cpu_ce), .sram_addr(sram_addr),
    .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n),
    .sram_lb_n(sram_lb_n)
  );

  fox86_memctl #(.WAIT(1)) dut_w1 (
    .clock(clock), .reset(reset), .cpu_address(cpu_address), .cpu_out(cpu_out),
    .cpu_we(cpu_we), .cpu_in(w1_cpu_in), .cpu_ce(w1_ce), .sram_addr(w1_addr),
    .sram_dq_o(w1_dq_o), .sram_dq_i(w1_dq_i), .sram_dq_oe(w1_dq_oe),
    .sram_oe_n(w1_oe_n), .sram_we_n(w1_we_n), .sram_ub_n(w1_ub_n),
    .sram_lb_n(w1_lb_n)
  );

  fox86_memctl #(.WAIT(4)) dut_w4 (
    .clock(clock), .reset(reset), .cpu_address(cpu_address), .cpu_out(cpu_out),
    .cpu_we(cpu_we), .cpu_in(w4_cpu_in), .cpu_ce(w4_ce), .sram_addr(w4_addr),
    .sram_dq_o(w4_dq_o), .sram_dq_i(w4_dq_i), .sram_dq_oe(w4_dq_oe),
    .sram_oe_n(w4_oe_n), .sram_we_n(w4_we_n), .sram_ub_n(w4_ub_n),
    .sram_lb_n(w4_lb_n)
  );

  // The period-check instances only need a fixed word at the top of memory.
  assign w1_dq_i = w1_oe_n ? 16'h0000 : ((w1_addr == 19'h7FFFF) ? 16'hA55A : 16'h0000);
  assign w4_dq_i = w4_oe_n ? 16'h0000 : ((w4_addr == 19'h7FFFF) ? 16'hA55A : 16'h0000);

  logic [15:0] mem [bit [18:0]];

  function automatic logic [15:0] rd(input logic [18:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  always @(negedge clock) sram_dq_i = sram_oe_n ? 16'h0000 : rd(sram_addr);

  // A write lands only when the strobe was held low for the full two-clock pulse width.
  int          we_run = 0;
  logic [18:0] pend_a;
  logic [15:0] pend_d;
  logic        pend_ub, pend_lb;
  always @(posedge clock) begin
    if (!sram_we_n) begin
      we_run++;
      pend_a  = sram_addr;
      pend_d  = sram_dq_o;
      pend_ub = sram_ub_n;
      pend_lb = sram_lb_n;
    end else begin
      if (we_run >= 2) begin
        logic [15:0] word;
        word = rd(pend_a);
        if (!pend_ub) word[15:8] = pend_d[15:8];
        if (!pend_lb) word[7:0] = pend_d[7:0];
        mem[pend_a] = word;
      end
      we_run = 0;
    end
  end

  int          acc_cycles, acc_we_low;
  logic        acc_ub_seen, acc_lb_seen, acc_overlap, acc_dqoe_seen;
  logic [18:0] acc_addr;
  logic [15:0] acc_dq;

  task automatic applyStimulus(input logic [19:0] a, input logic [7:0] d, input logic w);
    cpu_address = a;
    cpu_out     = d;
    cpu_we      = w;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Starts on a negedge where the core may present a new access and returns on
  // the negedge where cpu_ce is seen high, recording strobe activity on the way.
  task automatic runAccess(input logic [19:0] a, input logic [7:0] d, input logic w);
    applyStimulus(a, d, w);
    acc_cycles = 0; acc_we_low = 0; acc_ub_seen = 0; acc_lb_seen = 0;
    acc_overlap = 0; acc_dqoe_seen = 0; acc_addr = '0; acc_dq = '0;
    do begin
      @(negedge clock);
      acc_cycles++;
      if (!sram_we_n) acc_we_low++;
      if (!sram_ub_n) acc_ub_seen = 1'b1;
      if (!sram_lb_n) acc_lb_seen = 1'b1;
      if (!sram_oe_n && !sram_we_n) acc_overlap = 1'b1;
      if (sram_dq_oe) begin
        acc_dqoe_seen = 1'b1;
        acc_dq = sram_dq_o;
      end
      if (!sram_oe_n || sram_dq_oe) acc_addr = sram_addr;
    end while (!cpu_ce && acc_cycles < 50);
    if (!cpu_ce) checkOutput("access timeout", 32'(cpu_ce), 32'd1);
  endtask

  task automatic waitCe(input int which, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!((which == 1) ? w1_ce : w4_ce) && n < 100);
  endtask

  logic [19:0] rd_addrs [4] = '{20'h00000, 20'h00001, 20'h00020, 20'h00021};
  logic [7:0]  rd_exp   [4] = '{8'hA5, 8'hC3, 8'h1E, 8'h0F};

  initial begin
    int n;
    mem[19'h00008] = 16'hBEEF;
    mem[19'h78002] = 16'h1122;
    mem[19'h00000] = 16'hC3A5;
    mem[19'h00010] = 16'h0F1E;
    mem[19'h7FFFF] = 16'hD2C1;

    reset = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("reset ce", 32'(cpu_ce), 32'd0);
    checkOutput("reset cpu_in", 32'(cpu_in), 32'h00);
    checkOutput("reset addr", 32'(sram_addr), 32'h0);
    checkOutput("reset dq_o", 32'(sram_dq_o), 32'h0);
    checkOutput("reset dq_oe", 32'(sram_dq_oe), 32'd0);
    checkOutput("reset strobes", 32'({sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'hF);

    $display("[TB] read lower lane");
    reset = 1'b0;
    runAccess(20'h00010, 8'h00, 1'b0);
    checkOutput("rd1 latency", 32'(acc_cycles), 32'd5);
    checkOutput("rd1 data", 32'(cpu_in), 32'hEF);
    checkOutput("rd1 addr", 32'(acc_addr), 32'h8);
    checkOutput("rd1 lanes", 32'({acc_ub_seen, acc_lb_seen}), 32'b01);
    checkOutput("rd1 dq_oe", 32'(acc_dqoe_seen), 32'd0);

    $display("[TB] write upper lane");
    runAccess(20'h00011, 8'h5A, 1'b1);
    checkOutput("wr period", 32'(acc_cycles), 32'd5);
    checkOutput("wr we_n width", 32'(acc_we_low), 32'd2);
    checkOutput("wr lanes", 32'({acc_ub_seen, acc_lb_seen}), 32'b10);
    checkOutput("wr addr", 32'(acc_addr), 32'h8);
    checkOutput("wr dq_o", 32'(acc_dq), 32'h5A5A);
    checkOutput("wr cpu_in kept", 32'(cpu_in), 32'hEF);
    runAccess(20'h00011, 8'h00, 1'b0);
    checkOutput("wr readback", 32'(cpu_in), 32'h5A);
    checkOutput("wr mem word", 32'(rd(19'h8)), 32'h5AEF);

    $display("[TB] protected write");
    runAccess(20'hF0004, 8'h77, 1'b1);
    checkOutput("rom period", 32'(acc_cycles), 32'd5);
    checkOutput("rom we_n", 32'(acc_we_low), 32'd0);
    checkOutput("rom lanes", 32'({acc_ub_seen, acc_lb_seen}), 32'b00);
    checkOutput("rom cpu_in kept", 32'(cpu_in), 32'h5A);
    runAccess(20'hF0004, 8'h00, 1'b0);
    checkOutput("rom readback", 32'(cpu_in), 32'h22);
    checkOutput("rom mem word", 32'(rd(19'h78002)), 32'h1122);

    $display("[TB] back-to-back reads");
    for (int i = 0; i < 4; i++) begin
      runAccess(rd_addrs[i], 8'h00, 1'b0);
      checkOutput("b2b period", 32'(acc_cycles), 32'd5);
      checkOutput("b2b data", 32'(cpu_in), 32'(rd_exp[i]));
      checkOutput("b2b oe/we overlap", 32'(acc_overlap), 32'd0);
      checkOutput("b2b dq_oe", 32'(acc_dqoe_seen), 32'd0);
    end

    $display("[TB] reset during write strobe");
    applyStimulus(20'h00010, 8'hEE, 1'b1);
    repeat (3) @(negedge clock);
    checkOutput("rst pre we_n", 32'(sram_we_n), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("rst we_n", 32'(sram_we_n), 32'd1);
    checkOutput("rst ce", 32'(cpu_ce), 32'd0);
    checkOutput("rst others", 32'({sram_oe_n, sram_ub_n, sram_lb_n, sram_dq_oe}), 32'b1110);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    runAccess(20'h00010, 8'h00, 1'b0);
    checkOutput("rst first period", 32'(acc_cycles), 32'd5);
    checkOutput("rst byte kept", 32'(cpu_in), 32'hEF);
    checkOutput("rst mem word", 32'(rd(19'h8)), 32'h5AEF);

    $display("[TB] top address and WAIT variants");
    runAccess(20'hFFFFF, 8'h00, 1'b0);
    checkOutput("top data", 32'(cpu_in), 32'hD2);
    checkOutput("top addr", 32'(acc_addr), 32'h7FFFF);
    checkOutput("top lanes", 32'({acc_ub_seen, acc_lb_seen}), 32'b10);
    waitCe(1, n);
    waitCe(1, n);
    checkOutput("w1 period", 32'(n), 32'd4);
    checkOutput("w1 data", 32'(w1_cpu_in), 32'hA5);
    checkOutput("w1 addr", 32'(w1_addr), 32'h7FFFF);
    waitCe(4, n);
    waitCe(4, n);
    checkOutput("w4 period", 32'(n), 32'd7);
    checkOutput("w4 data", 32'(w4_cpu_in), 32'hA5);
    checkOutput("w4 addr", 32'(w4_addr), 32'h7FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
